// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   MEM-stage bridge to the 16-bit data SRAM. Each 32-bit LDR/STR is split
//   into a LOW half access followed by a HIGH half access. Each half is held
//   for WAIT_CYCLES cycles. ready stays low until the word completes, which
//   freezes the pipeline for the duration of the access.
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        op_wr;
  logic        cur_wr;
  logic        req;
  logic        phase_end;
  logic [31:0] off;
  logic        unused_off;

  assign req       = rd_en | wr_en;
  assign off       = address - 32'(BASE_ADDR);
  assign phase_end = (cnt == CNT_LAST);
  // The op is not latched yet on the IDLE->LOW edge, so use the live request there.
  assign cur_wr    = (state == IDLE) ? wr_en : op_wr;
  assign ready     = (state == DONE) | ((state == IDLE) & ~req);

  // Word-offset bits above the SRAM range and the byte-lane bits are ignored.
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

  // Next state and phase counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and latched operation type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if ((state == IDLE) && req) begin
        op_wr <= wr_en;
      end
    end
  end

  // SRAM pins are registered from the next state so they line up with the phase cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else if ((state_nx == LOW) || (state_nx == HIGH)) begin
      sram_addr   <= {off[SRAM_AW:2], (state_nx == HIGH)};
      sram_dq_out <= (state_nx == HIGH) ? write_data[31:16] : write_data[15:0];
      sram_dq_oe  <= cur_wr;
      // Strobe released on the last cycle so address and data outlast it.
      sram_we_n   <= ~(cur_wr && (cnt_nx != CNT_LAST));
    end else begin
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end
  end

  // Load result capture on the last cycle of each read phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!op_wr && phase_end) begin
      if (state == LOW) begin
        read_data[15:0] <= sram_dq_in;
      end else if (state == HIGH) begin
        read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural 16-bit SRAM.
module tb_sram_mem_controller;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int tests;
  int failed;

  typedef struct {
    logic        wr;
    logic [17:0] lo;
    logic [31:0] data;
    logic [31:0] rd;
  } rec_t;

  rec_t sb[$];

  logic [15:0] mem [0:262143];

  sram_mem_controller #(
    .BASE_ADDR(1024),
    .WAIT_CYCLES(3),
    .SRAM_AW(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write on clock edge while the strobe is low.
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [17:0] lo,
                       input logic [31:0] exp_rd);
    rec_t r;
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = d;
    r.wr = wr;
    r.lo = lo;
    r.data = d;
    r.rd = exp_rd;
    sb.push_back(r);
  endtask

  // Returns at the falling edge of the DONE cycle.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: ready=%0b after %0d cycles, expected 1", name, ready, n);
    end
  endtask

  task automatic idle_inputs();
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  // Monitor: checks each stalled cycle against the front record and pops it when ready returns.
  initial begin : monitor
    int stall;
    int perr;
    int c;
    logic exp_we_n;
    logic [17:0] exp_addr;
    rec_t r;
    stall = 0;
    perr = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        stall = 0;
        perr = 0;
      end else if (!ready) begin
        c = stall;
        stall++;
        if (sb.size() == 0) begin
          perr++;
        end else begin
          r = sb[0];
          if (c >= 1 && c <= 6) begin
            exp_addr = (c <= 3) ? r.lo : r.lo + 18'd1;
            exp_we_n = !(r.wr && (c == 1 || c == 2 || c == 4 || c == 5));
            if (sram_addr !== exp_addr) perr++;
            if (sram_we_n !== exp_we_n) perr++;
            if (sram_dq_oe !== r.wr) perr++;
            if (r.wr && sram_dq_out !== ((c <= 3) ? r.data[15:0] : r.data[31:16])) perr++;
          end else if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            perr++;
          end
        end
      end else if (stall > 0) begin
        tests++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL sb_unexpected: completion with empty scoreboard, got %0d stall cycles, expected none", stall);
        end else begin
          r = sb.pop_front();
          check("stall_cycles", 32'(stall), 32'd7);
          check("phase_errors", 32'(perr), 32'd0);
          check("done_pins", {30'd0, sram_we_n, sram_dq_oe}, 32'h2);
          check("read_data", read_data, r.rd);
          if (r.wr) begin
            check("mem_lo", {16'd0, mem[r.lo]}, {16'd0, r.data[15:0]});
            check("mem_hi", {16'd0, mem[r.lo + 18'd1]}, {16'd0, r.data[31:16]});
          end
        end
        stall = 0;
        perr = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    tests = 0;
    failed = 0;
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 3: LDR 1028 -> 0xABCD1234, held after return to IDLE
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hABCD1234);
    wait_done("ldr");
    idle_inputs();
    repeat (3) @(negedge clk);
    check("ldr_hold", read_data, 32'hABCD1234);
    check("idle_ready", {31'd0, ready}, 32'd1);

    // 2: STR 1028 0xDEADBEEF, read_data untouched
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'hABCD1234);
    wait_done("str");
    idle_inputs();

    // 4: back-to-back STR then LDR at 1024; second request appears during DONE
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 32'd1024, 32'h13579BDF, 18'd0, 32'hABCD1234);
    wait_done("b2b_str");
    issue(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h13579BDF);
    @(negedge clk);
    check("b2b_gap_ready", {31'd0, ready}, 32'd0);
    wait_done("b2b_ldr");
    idle_inputs();

    // 5: rd_en and wr_en together -> write
    @(posedge clk);
    #1;
    issue(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4, 32'h13579BDF);
    wait_done("both");
    idle_inputs();

    // Aliasing: address 0 maps to off 0xFFFFFC00 -> SRAM word 0x3FE00
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 32'd0, 32'h11112222, 18'h3FE00, 32'h13579BDF);
    wait_done("alias");
    idle_inputs();

    // 6: reset pulsed in HIGH of a write, request held so the access restarts
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, 18'd6, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_read_data", read_data, 32'h0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    #1;
    rst = 1'b0;
    wait_done("restart");
    idle_inputs();

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
